// File: rtl/mole_field_if.sv
// Bus between the whack-a-mole game controller and the mole field:
// game state, tick, spawn and whack requests in, mole map and result pulses out.
interface mole_field_if #(
    parameter int NUM_HOLES = 16,
    parameter int MAX_MOLES = 4,
    parameter int LIFE_W    = 8
);
    localparam int LW = $clog2(NUM_HOLES);
    localparam int CW = $clog2(MAX_MOLES + 1);

    logic [1:0]           game_state_i;
    logic                 tick_i;
    logic                 spawn_valid_i;
    logic [LW-1:0]        spawn_loc_i;
    logic [LIFE_W-1:0]    spawn_life_i;
    logic                 spawn_ready_o;
    logic                 whack_valid_i;
    logic [LW-1:0]        whack_loc_i;
    logic [NUM_HOLES-1:0] mole_o;
    logic                 hit_o;
    logic                 miss_o;
    logic [CW-1:0]        escape_cnt_o;
    logic [CW-1:0]        active_cnt_o;

    modport master (
        output game_state_i, tick_i, spawn_valid_i, spawn_loc_i, spawn_life_i,
        output whack_valid_i, whack_loc_i,
        input  spawn_ready_o, mole_o, hit_o, miss_o, escape_cnt_o, active_cnt_o
    );

    modport slave (
        input  game_state_i, tick_i, spawn_valid_i, spawn_loc_i, spawn_life_i,
        input  whack_valid_i, whack_loc_i,
        output spawn_ready_o, mole_o, hit_o, miss_o, escape_cnt_o, active_cnt_o
    );
endinterface

// File: rtl/mole_field.sv
// Mole field: a small pool of mole slots that spawn into holes, age on game
// ticks and disappear when whacked or expired. All decisions use pre-edge state.
module mole_field #(
    parameter int NUM_HOLES = 16,
    parameter int MAX_MOLES = 4,
    parameter int LIFE_W    = 8
) (
    input  logic        clock_i,
    input  logic        reset_i,
    mole_field_if.slave bus
);
    localparam int LW = $clog2(NUM_HOLES);
    localparam int CW = $clog2(MAX_MOLES + 1);
    localparam int SW = (MAX_MOLES > 1) ? $clog2(MAX_MOLES) : 1;
    localparam logic [1:0] PLAY = 2'b10;

    logic [MAX_MOLES-1:0] r_valid;
    logic [LW-1:0]        r_loc  [MAX_MOLES];
    logic [LIFE_W-1:0]    r_life [MAX_MOLES];
    logic [NUM_HOLES-1:0] r_mole;
    logic                 r_hit;
    logic                 r_miss;
    logic [CW-1:0]        r_escape;
    logic [CW-1:0]        r_active;

    logic [MAX_MOLES-1:0] w_valid;
    logic [LW-1:0]        w_loc  [MAX_MOLES];
    logic [LIFE_W-1:0]    w_life [MAX_MOLES];
    logic [NUM_HOLES-1:0] w_mole;
    logic                 w_hit;
    logic                 w_miss;
    logic [CW-1:0]        w_escape;
    logic [CW-1:0]        w_active;
    logic                 w_play;
    logic                 w_has_free;
    logic [SW-1:0]        w_free_idx;
    logic                 w_occupied;
    logic                 w_whack_match;
    logic                 w_accept;

    assign w_play = (bus.game_state_i == PLAY);

    // Next-state computation for every slot plus the registered result outputs.
    always_comb begin
        w_valid       = r_valid;
        w_loc         = r_loc;
        w_life        = r_life;
        w_hit         = 1'b0;
        w_miss        = 1'b0;
        w_escape      = '0;
        w_mole        = '0;
        w_active      = '0;
        w_has_free    = 1'b0;
        w_free_idx    = '0;
        w_occupied    = 1'b0;
        w_whack_match = 1'b0;

        // Scanning downwards leaves the lowest free slot index in w_free_idx.
        for (int i = MAX_MOLES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_has_free = 1'b1;
                w_free_idx = SW'(i);
            end else begin
                w_occupied = w_occupied | (r_loc[i] == bus.spawn_loc_i);
            end
        end
        w_accept = w_play && bus.spawn_valid_i && w_has_free;

        if (w_play) begin
            for (int i = 0; i < MAX_MOLES; i++) begin
                if (r_valid[i] && bus.whack_valid_i && (r_loc[i] == bus.whack_loc_i)) begin
                    w_valid[i]    = 1'b0;
                    w_whack_match = 1'b1;
                end else if (r_valid[i] && bus.tick_i) begin
                    if (r_life[i] == LIFE_W'(1)) begin
                        w_valid[i] = 1'b0;
                        w_escape   = w_escape + CW'(1);
                    end else begin
                        w_life[i] = r_life[i] - LIFE_W'(1);
                    end
                end else begin
                    w_valid[i] = r_valid[i];
                end
            end
            w_hit  = bus.whack_valid_i && w_whack_match;
            w_miss = bus.whack_valid_i && !w_whack_match;
            // A spawn onto an occupied hole is consumed but changes nothing.
            if (w_accept && !w_occupied) begin
                w_valid[w_free_idx] = 1'b1;
                w_loc[w_free_idx]   = bus.spawn_loc_i;
                w_life[w_free_idx]  = (bus.spawn_life_i == '0) ? LIFE_W'(1) : bus.spawn_life_i;
            end else begin
                w_valid[w_free_idx] = w_valid[w_free_idx];
            end
        end else begin
            w_valid = '0;
        end

        for (int i = 0; i < MAX_MOLES; i++) begin
            w_mole   = w_mole | ((NUM_HOLES'(1) << w_loc[i]) & {NUM_HOLES{w_valid[i]}});
            w_active = w_active + CW'(w_valid[i]);
        end
    end

    // Slot state and registered outputs.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_valid  <= '0;
            for (int i = 0; i < MAX_MOLES; i++) begin
                r_loc[i]  <= '0;
                r_life[i] <= '0;
            end
            r_mole   <= '0;
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
            r_escape <= '0;
            r_active <= '0;
        end else begin
            r_valid  <= w_valid;
            r_loc    <= w_loc;
            r_life   <= w_life;
            r_mole   <= w_mole;
            r_hit    <= w_hit;
            r_miss   <= w_miss;
            r_escape <= w_escape;
            r_active <= w_active;
        end
    end

    assign bus.spawn_ready_o = w_play && w_has_free;
    assign bus.mole_o        = r_mole;
    assign bus.hit_o         = r_hit;
    assign bus.miss_o        = r_miss;
    assign bus.escape_cnt_o  = r_escape;
    assign bus.active_cnt_o  = r_active;
endmodule
